// File: rtl/mmu_pkg.sv
//==============================================================================
// Module      : mmu_pkg
// Description : Shared widths and step constants for the 2x2 MMU systolic array.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mmu_pkg;

    localparam int DATA_W         = 8;
    localparam int ACC_W          = 18;
    localparam int STEPS_TO_VALID = 4;
    localparam int STEP_W         = 3;

    typedef logic [STEP_W-1:0] step_t;

endpackage : mmu_pkg

`default_nettype wire

// File: rtl/mmu_pe.sv
//==============================================================================
// Module      : mmu_pe
// Description : Output-stationary processing element: multiply-accumulate plus
//               one-step forwarding of both operands to its neighbours.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmu_pe #(
    parameter int DATA_W = mmu_pkg::DATA_W,
    parameter int ACC_W  = mmu_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_fwd,
    output logic [DATA_W-1:0] b_fwd,
    output logic [ACC_W-1:0]  acc
);

    import mmu_pkg::*;

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_a_fwd;
    logic [DATA_W-1:0]   r_b_fwd;

    assign w_prod = a_in * b_in;

    // Accumulator wraps modulo 2^ACC_W; the product is zero-extended.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc   <= '0;
            r_a_fwd <= '0;
            r_b_fwd <= '0;
        end else if (en) begin
            r_acc   <= r_acc + ACC_W'(w_prod);
            r_a_fwd <= a_in;
            r_b_fwd <= b_in;
        end
    end

    assign acc   = r_acc;
    assign a_fwd = r_a_fwd;
    assign b_fwd = r_b_fwd;

endmodule : mmu_pe

`default_nettype wire

// File: rtl/mmu_array_2x2.sv
//==============================================================================
// Module      : mmu_array_2x2
// Description : 2x2 output-stationary systolic array computing C = A x B from
//               skewed row/column operand streams, with optional saturation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmu_array_2x2 #(
    parameter int DATA_W   = mmu_pkg::DATA_W,
    parameter int ACC_W    = mmu_pkg::ACC_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a_data0,
    input  logic [DATA_W-1:0] a_data1,
    input  logic [DATA_W-1:0] b_data0,
    input  logic [DATA_W-1:0] b_data1,
    output logic [DATA_W-1:0] c_0,
    output logic [DATA_W-1:0] c_1,
    output logic [DATA_W-1:0] c_2,
    output logic [DATA_W-1:0] c_3,
    output logic              valid
);

    import mmu_pkg::*;

    localparam step_t C_STEP_DONE = step_t'(STEPS_TO_VALID);
    localparam step_t C_STEP_ONE  = step_t'(1);

    logic [DATA_W-1:0]          w_a00_fwd;
    logic [DATA_W-1:0]          w_b00_fwd;
    logic [DATA_W-1:0]          w_b01_fwd;
    logic [DATA_W-1:0]          w_a10_fwd;
    logic [DATA_W-1:0]          w_a01_fwd_unused;
    logic [DATA_W-1:0]          w_b10_fwd_unused;
    logic [DATA_W-1:0]          w_a11_fwd_unused;
    logic [DATA_W-1:0]          w_b11_fwd_unused;
    logic [3:0][ACC_W-1:0]      w_acc;
    logic [3:0][DATA_W-1:0]     w_c;

    step_t                      r_step;
    logic                       r_valid;

    // A flows left-to-right along rows, B flows top-to-bottom along columns.
    mmu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe00 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (en),
        .a_in  (a_data0),
        .b_in  (b_data0),
        .a_fwd (w_a00_fwd),
        .b_fwd (w_b00_fwd),
        .acc   (w_acc[0])
    );

    mmu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe01 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (en),
        .a_in  (w_a00_fwd),
        .b_in  (b_data1),
        .a_fwd (w_a01_fwd_unused),
        .b_fwd (w_b01_fwd),
        .acc   (w_acc[1])
    );

    mmu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe10 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (en),
        .a_in  (a_data1),
        .b_in  (w_b00_fwd),
        .a_fwd (w_a10_fwd),
        .b_fwd (w_b10_fwd_unused),
        .acc   (w_acc[2])
    );

    mmu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe11 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (en),
        .a_in  (w_a10_fwd),
        .b_in  (w_b01_fwd),
        .a_fwd (w_a11_fwd_unused),
        .b_fwd (w_b11_fwd_unused),
        .acc   (w_acc[3])
    );

    // Step counter saturates at the done value so valid latches until clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_step  <= '0;
            r_valid <= 1'b0;
        end else if (en && (r_step != C_STEP_DONE)) begin
            r_step  <= r_step + C_STEP_ONE;
            r_valid <= (r_step == (C_STEP_DONE - C_STEP_ONE));
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_out
        if (SATURATE) begin : g_sat
            assign w_c[k] = (|w_acc[k][ACC_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                                        : w_acc[k][DATA_W-1:0];
        end else begin : g_wrap
            assign w_c[k] = w_acc[k][DATA_W-1:0];
        end
    end

    assign c_0   = w_c[0];
    assign c_1   = w_c[1];
    assign c_2   = w_c[2];
    assign c_3   = w_c[3];
    assign valid = r_valid;

endmodule : mmu_array_2x2

`default_nettype wire

// File: tb/tb_mmu_array_2x2.sv
//==============================================================================
// Module      : tb_mmu_array_2x2
// Description : Scoreboard bench for mmu_array_2x2 with saturating and
//               wrapping instances driven from the same operand streams.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mmu_array_2x2;

    typedef logic [7:0] mat_t [4];

    typedef struct {
        string       name;
        logic [31:0] sat;
        logic [31:0] wrap;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic [7:0] a_data0 = '0;
    logic [7:0] a_data1 = '0;
    logic [7:0] b_data0 = '0;
    logic [7:0] b_data1 = '0;

    logic [7:0] s_c0, s_c1, s_c2, s_c3;
    logic [7:0] w_c0, w_c1, w_c2, w_c3;
    logic       s_valid, w_valid;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmu_array_2x2 #(.DATA_W(8), .ACC_W(18), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .en(en),
        .a_data0(a_data0), .a_data1(a_data1), .b_data0(b_data0), .b_data1(b_data1),
        .c_0(s_c0), .c_1(s_c1), .c_2(s_c2), .c_3(s_c3), .valid(s_valid)
    );

    mmu_array_2x2 #(.DATA_W(8), .ACC_W(18), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clear(clear), .en(en),
        .a_data0(a_data0), .a_data1(a_data1), .b_data0(b_data0), .b_data1(b_data1),
        .c_0(w_c0), .c_1(w_c1), .c_2(w_c2), .c_3(w_c3), .valid(w_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic step(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic e_i, input logic clr_i, input logic rst_i);
        a_data0 = a0;
        a_data1 = a1;
        b_data0 = b0;
        b_data1 = b1;
        en      = e_i;
        clear   = clr_i;
        rst     = rst_i;
        @(posedge clk);
        #1;
    endtask

    // Clear, then feed s0..s3 with optional en=0 stall between s1 and s2.
    task automatic run(input string name, input mat_t a, input mat_t b, input int stall,
                       input logic [31:0] esat, input logic [31:0] ewrap);
        step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back('{name, esat, ewrap, cyc + 4 + stall});
        step(a[0], 8'd0, b[0], 8'd0, 1'b1, 1'b0, 1'b0);
        step(a[1], a[2], b[2], b[1], 1'b1, 1'b0, 1'b0);
        repeat (stall) step(8'd0, a[3], 8'd0, b[3], 1'b0, 1'b0, 1'b0);
        step(8'd0, a[3], 8'd0, b[3], 1'b1, 1'b0, 1'b0);
        step(8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_sat_c"}, {s_c0, s_c1, s_c2, s_c3}, 32'd0);
        check({name, "_wrap_c"}, {w_c0, w_c1, w_c2, w_c3}, 32'd0);
        check({name, "_valid"}, {30'd0, s_valid, w_valid}, 32'd0);
    endtask

    // Monitor: compare each completed result against the scoreboard on valid rise.
    always @(negedge clk) begin
        if (s_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected no result", cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_latency"}, cyc, e.cyc);
                check({e.name, "_sat_c"}, {s_c0, s_c1, s_c2, s_c3}, e.sat);
                check({e.name, "_wrap_c"}, {w_c0, w_c1, w_c2, w_c3}, e.wrap);
                check({e.name, "_wrap_valid"}, {31'd0, w_valid}, 32'd1);
            end
        end
        prev_valid = s_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mat_t a_basic, b_basic, a_20, a_id;
        a_basic = '{8'd1, 8'd2, 8'd3, 8'd4};
        b_basic = '{8'd5, 8'd6, 8'd7, 8'd8};
        a_20    = '{8'd20, 8'd20, 8'd20, 8'd20};
        a_id    = '{8'd1, 8'd0, 8'd0, 8'd1};

        repeat (2) step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        check_zero("reset");
        step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        run("basic", a_basic, b_basic, 0,
            {8'd19, 8'd22, 8'd43, 8'd50}, {8'd19, 8'd22, 8'd43, 8'd50});

        repeat (5) step(8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        check("hold_sat_c", {s_c0, s_c1, s_c2, s_c3}, {8'd19, 8'd22, 8'd43, 8'd50});
        check("hold_wrap_c", {w_c0, w_c1, w_c2, w_c3}, {8'd19, 8'd22, 8'd43, 8'd50});
        check("hold_valid", {30'd0, s_valid, w_valid}, 32'd3);

        run("saturate", a_20, a_20, 0,
            {8'd255, 8'd255, 8'd255, 8'd255}, {8'd32, 8'd32, 8'd32, 8'd32});

        run("stall", a_basic, b_basic, 3,
            {8'd19, 8'd22, 8'd43, 8'd50}, {8'd19, 8'd22, 8'd43, 8'd50});

        // Clear together with en at s1 discards the step.
        step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(8'd1, 8'd0, 8'd5, 8'd0, 1'b1, 1'b0, 1'b0);
        step(8'd2, 8'd3, 8'd7, 8'd6, 1'b1, 1'b1, 1'b0);
        check_zero("clear_prio");
        run("after_clear", a_basic, b_basic, 0,
            {8'd19, 8'd22, 8'd43, 8'd50}, {8'd19, 8'd22, 8'd43, 8'd50});

        // Reset pulse at s2 aborts the run.
        step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(8'd1, 8'd0, 8'd5, 8'd0, 1'b1, 1'b0, 1'b0);
        step(8'd2, 8'd3, 8'd7, 8'd6, 1'b1, 1'b0, 1'b0);
        step(8'd0, 8'd4, 8'd0, 8'd8, 1'b1, 1'b0, 1'b1);
        check_zero("reset_mid");
        run("identity", a_id, a_id, 0,
            {8'd1, 8'd0, 8'd0, 8'd1}, {8'd1, 8'd0, 8'd0, 8'd1});

        repeat (3) step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mmu_array_2x2

`default_nettype wire
